hilo_muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside ALU32Bit, taking the same A/B operands from the ID/EX register. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. It drives a Busy stall to the hazard unit, and its HI/LO outputs feed the MFHI/MFLO result mux downstream of the ALU.

---
 rtl/hilo_muldiv_unit_pkg.sv | 25 ++
 rtl/hilo_muldiv_unit_if.sv | 20 ++
 rtl/muldiv_iter_core.sv | 41 ++++
 rtl/hilo_muldiv_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - op codes presented on the Op input (6 and 7 are reserved no-ops)
//   - FSM state encodings
//   - default operand width and iteration count
package hilo_pkg;

  localparam int BITS_DEFAULT = 32;
  localparam int ITER_DEFAULT = BITS_DEFAULT;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO mul/div unit.
//   Start, Op, A, B : request from the pipeline (master drives)
//   Busy            : stall while a mul/div is in flight
//   Done            : one-cycle pulse when HI/LO take a mul/div result
//   HI, LO          : architectural HI/LO registers
interface hilo_muldiv_unit_if #(
  parameter int BITS_SIZE = 32
);
  logic                 Start;
  logic [2:0]           Op;
  logic [BITS_SIZE-1:0] A;
  logic [BITS_SIZE-1:0] B;
  logic                 Busy;
  logic                 Done;
  logic [BITS_SIZE-1:0] HI;
  logic [BITS_SIZE-1:0] LO;

  modport master (output Start, Op, A, B, input Busy, Done, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/muldiv_iter_core.sv
// One iteration of the shared mul/div datapath (purely combinational).
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : 2*BITS_SIZE accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, dividend/quotient bits}
//   opd_i    : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o    : accumulator after this iteration
module muldiv_iter_core #(
  parameter int BITS_SIZE = 32
) (
  input  logic                   is_div_i,
  input  logic [2*BITS_SIZE-1:0] acc_i,
  input  logic [BITS_SIZE-1:0]   opd_i,
  output logic [2*BITS_SIZE-1:0] acc_o
);
  localparam int N = BITS_SIZE;

  logic [N:0]   sum;
  logic [N:0]   rs;
  logic [N-1:0] diff;
  logic         ge;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit (LSB) is set, then shift the whole accumulator right,
    // carry included.
    sum  = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? {1'b0, opd_i} : {(N+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and try to
    // subtract. Compared at N+1 bits so a divide by zero keeps taking the
    // subtract path (quotient all ones, remainder = dividend).
    rs   = {acc_i[2*N-1:N], acc_i[N-1]};
    ge   = (rs >= {1'b0, opd_i});
    diff = rs[N-1:0] - opd_i;
    if (is_div_i) begin
      acc_o = ge ? {diff, acc_i[N-2:0], 1'b1} : {rs[N-1:0], acc_i[N-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[N-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   Clk  : clock, rising edge
//   Rst  : asynchronous, active-high reset
//   bus  : slave side of hilo_muldiv_unit_if (Start/Op/A/B in,
//          Busy/Done/HI/LO out)
// MULT/MULTU/DIV/DIVU run on magnitudes for ITER cycles, then a FIX cycle
// applies sign correction and writes HI/LO. MTHI/MTLO write in one cycle.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int BITS_SIZE = BITS_DEFAULT,
  parameter int ITER      = BITS_SIZE
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hilo_muldiv_unit_if.slave     bus
);
  localparam int N     = BITS_SIZE;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef logic [N-1:0] word_t;

  function automatic word_t neg(input word_t x);
    return word_t'(-x);
  endfunction

  function automatic word_t mag(input word_t x);
    return x[N-1] ? neg(x) : x;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]     acc_q, acc_d;
  word_t              opd_q, opd_d;
  logic               is_div_q, is_div_d;
  logic               res_sign_q, res_sign_d;
  logic               rem_sign_q, rem_sign_d;
  logic               div0_q, div0_d;
  word_t              hi_q, hi_d;
  word_t              lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*N-1:0]     acc_step;
  logic [2*N-1:0]     prod;
  logic               signed_op;
  logic               div_op;
  word_t              a_m;
  word_t              b_m;

  muldiv_iter_core #(.BITS_SIZE(N)) u_core (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opd_i    (opd_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opd_d      = opd_q;
    is_div_d   = is_div_q;
    res_sign_d = res_sign_q;
    rem_sign_d = rem_sign_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    signed_op  = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    div_op     = bus.Op[1];
    a_m        = signed_op ? mag(bus.A) : bus.A;
    b_m        = signed_op ? mag(bus.B) : bus.B;
    prod       = res_sign_q ? (~acc_q + 1'b1) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (!bus.Op[2]) begin
            // Multiply seeds the low half with the multiplier; divide seeds
            // it with the dividend. The high half starts at zero either way.
            acc_d      = {{N{1'b0}}, (div_op ? a_m : b_m)};
            opd_d      = div_op ? b_m : a_m;
            is_div_d   = div_op;
            res_sign_d = signed_op & (bus.A[N-1] ^ bus.B[N-1]);
            rem_sign_d = signed_op & div_op & bus.A[N-1];
            div0_d     = div_op & (bus.B == '0);
            cnt_d      = '0;
            state_d    = ST_RUN;
          end else if (bus.Op == OP_MTHI) begin
            hi_d = bus.A;
          end else if (bus.Op == OP_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          // Divide by zero forces an all-ones quotient. The remainder path
          // still restores A, since |A| re-negated by remSign gives A back.
          lo_d = div0_q ? '1 : (res_sign_q ? neg(acc_q[N-1:0]) : acc_q[N-1:0]);
          hi_d = rem_sign_q ? neg(acc_q[2*N-1:N]) : acc_q[2*N-1:N];
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      res_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opd_q      <= opd_d;
      is_div_q   <= is_div_d;
      res_sign_q <= res_sign_d;
      rem_sign_q <= rem_sign_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign bus.Busy = (state_q != ST_IDLE);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
